ram128x16_ctrl: RTL
===================

Name: ram128x16_ctrl

Overview:
- Sequencing controller and two-requester arbiter for the 128x16 RAM bank.
- The bank is 8 rows x 4 columns of ram16x4 chips. Each row holds 16 words; each 16-bit word spans 4 chips.
- Converts clocked valid/ready requests into the chips' active-low _ce/_we/_oe strobe sequence with setup/strobe/hold phases.
- Owns the write-data tri-state enable and captures read data.

Parameters:
- STROBE_CYCLES, 2: cycles _we or _oe is held low; legal range 1..15.
- ROWS, 8: number of chip rows (one _ce per row); address width = 4 + log2(ROWS).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_we  in  1  1 = write, 0 = read
- req0_addr  in  7  word address
- req0_wdata  in  16  write data
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata: same as requester 0, for requester 1
- rsp_valid  out  1  read data valid pulse
- rsp_id  out  1  requester that owns rsp_rdata
- rsp_rdata  out  16  read data
- mem_adrs  out  4  chip address (addr[3:0])
- mem_ce_n  out  ROWS  per-row chip enable, active low, one-hot-low
- mem_we_n  out  1  write strobe, active low
- mem_oe_n  out  1  output enable, active low
- mem_wdata  out  16  data driven onto the shared bus
- mem_wdata_en  out  1  bus driver enable (1 only during a write transaction)
- mem_rdata  in  16  data read back from the selected row
- busy  out  1  transaction in progress

Behaviour:
- Reset values:
  - mem_ce_n all 1; mem_we_n 1; mem_oe_n 1.
  - mem_wdata_en 0; mem_adrs 0; mem_wdata 0.
  - rsp_valid 0; rsp_id 0; rsp_rdata 0; busy 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
- Reset mid-transaction aborts immediately: strobes return high on the next edge and no rsp_valid is issued.
- FSM states IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - Arbitration is combinational. If exactly one valid, grant it. If both valid, grant the requester != last_grant.
  - reqN_ready = (state == IDLE) && grant == N. Both readys are never high together.
  - On valid & ready: latch we, addr, wdata; update last_grant; go to SETUP.
- SETUP (1 cycle):
  - mem_adrs = addr[3:0].
  - mem_ce_n[addr[6:4]] = 0, all other rows 1.
  - For writes: mem_wdata_en = 1 and mem_wdata = latched data.
  - mem_we_n and mem_oe_n stay 1.
- STROBE (STROBE_CYCLES cycles, internal down-counter):
  - Write: mem_we_n = 0. Read: mem_oe_n = 0.
  - Address, ce and write data held stable.
  - Read: on the last STROBE cycle, mem_rdata is registered into rsp_rdata.
- HOLD (1 cycle):
  - we_n and oe_n return to 1; address, ce and wdata_en held.
  - For reads, rsp_valid = 1 and rsp_id = owner during this cycle only.
  - Next state IDLE, with ce_n all 1 and wdata_en 0.
- mem_we_n and mem_oe_n are never low simultaneously. Neither is ever low while all mem_ce_n are high.
- Timing: acceptance at cycle T gives SETUP at T+1, STROBE at T+2..T+1+S, HOLD at T+2+S, next acceptance no earlier than T+3+S.
  - With default S = 2: 5 cycles per transaction; read rsp_valid at T+4.
- busy = (state != IDLE).
- Requests arriving during a transaction wait; valid must stay high until ready.
- Address wrap: addr 127 selects row 7, chip address 0xF. No wrap logic; all 128 addresses are legal.
- rsp_rdata retains its last value between reads. Writes never pulse rsp_valid.

Decomposition:
- Shared package ram_pkg:
  - WORD_W = 16, CHIP_AW = 4, ROWS = 8.
  - State enum {IDLE, SETUP, STROBE, HOLD}.
  - Request record typedef (we, addr, wdata).
- One natural sub-module: rr_arb2, the two-way round-robin arbiter holding last_grant.
- Row decode and FSM remain in the top level.

Test Plan:
- Write/read same word: req0 write addr 0x25 data 0xBEEF, then req0 read 0x25.
  - Write: mem_ce_n = 8'b1111_1011 and mem_adrs = 5 for SETUP+STROBE+HOLD; mem_we_n low exactly 2 cycles.
  - Read: rsp_valid at acceptance+4 with rsp_rdata = 0xBEEF, rsp_id = 0.
- Tie arbitration: req0 and req1 both continuously valid, 4 reads each.
  - Grants alternate 0, 1, 0, 1, ...
  - Each acceptance 5 cycles apart; readys never both high.
- Full sweep: write addr i with data {i, ~i} for i = 0..127, then read back all 128.
  - Every read matches.
  - Each mem_ce_n row is asserted for exactly 16 writes and 16 reads.
- Strobe checker across all tests:
  - we_n and oe_n never low together.
  - No strobe while all ce_n are high.
  - wdata_en low during reads.
- Reset mid-strobe: assert rst during STROBE of a read.
  - Next cycle: all strobes high, busy 0, no rsp_valid.
  - After release, a fresh request from req0 wins first.
- STROBE_CYCLES = 4 build: write then read.
  - we_n low exactly 4 cycles.
  - rsp_valid at acceptance+6.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the 128x16 RAM bank controller
package ram_pkg;

  localparam int WORD_W  = 16;
  localparam int CHIP_AW = 4;
  localparam int ROWS    = 8;
  localparam int ADDR_W  = CHIP_AW + $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; a tie goes to the requester not granted last
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic update,
  output logic grant,
  output logic grant_valid
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = ~last_grant_q;
    end else begin
      grant = valid1;
    end
    last_grant_d = update ? grant : last_grant_q;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ram128x16_ctrl.sv
// rtl/ram128x16_ctrl.sv - arbitrated setup/strobe/hold sequencer for the ram16x4 chip array
module ram128x16_ctrl
  import ram_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int ROWS          = ram_pkg::ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WORD_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WORD_W-1:0] req1_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic [CHIP_AW-1:0] mem_adrs,
  output logic [ROWS-1:0]   mem_ce_n,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_wdata_en,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = 4;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              owner_q, owner_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic grant;
  logic grant_valid;
  logic accept;

  assign accept = (state_q == IDLE) && grant_valid;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .update      (accept),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      owner_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (cnt_q == '0) state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (accept) begin
      owner_d = grant;
      req_d   = grant ? '{we: req1_we, addr: req1_addr, wdata: req1_wdata}
                      : '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
    end
    // Counter is loaded in SETUP so it reaches zero on the final strobe cycle.
    if (state_q == SETUP) begin
      cnt_d = CNT_W'(STROBE_CYCLES - 1);
    end
    if (state_q == STROBE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (!req_q.we) begin
        rdata_d = mem_rdata;
      end
    end
  end

  always_comb begin
    mem_adrs     = '0;
    mem_ce_n     = '1;
    mem_we_n     = 1'b1;
    mem_oe_n     = 1'b1;
    mem_wdata    = '0;
    mem_wdata_en = 1'b0;
    rsp_valid    = 1'b0;
    rsp_id       = 1'b0;
    rsp_rdata    = rdata_q;
    busy         = (state_q != IDLE);
    if (state_q != IDLE) begin
      mem_adrs = req_q.addr[CHIP_AW-1:0];
      mem_ce_n[req_q.addr[ADDR_W-1:CHIP_AW]] = 1'b0;
      if (req_q.we) begin
        mem_wdata_en = 1'b1;
        mem_wdata    = req_q.wdata;
      end
    end
    if (state_q == STROBE) begin
      if (req_q.we) begin
        mem_we_n = 1'b0;
      end else begin
        mem_oe_n = 1'b0;
      end
    end
    if (state_q == HOLD && !req_q.we) begin
      rsp_valid = 1'b1;
      rsp_id    = owner_q;
    end
  end

endmodule
